// File: rtl/ibert_pkg.sv
// Shared types and per-polynomial constants for the PRBS checker and its LFSR.
// No logic; no latency or backpressure of its own.
package ibert_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    VERIFY,
    LOCKED,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS9  = 2'd1,
    PRBS15 = 2'd2,
    PRBS23 = 2'd3
  } poly_t;

  localparam int LFSR_W     = 23;
  localparam int BLOCK_SIZE = 64;

  // Indexed by poly_t: register length and the second feedback tap.
  localparam logic [4:0] POLY_LEN [4] = '{5'd7, 5'd9, 5'd15, 5'd23};
  localparam logic [4:0] POLY_TAP [4] = '{5'd6, 5'd5, 5'd14, 5'd18};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Poly-selectable 23-bit Fibonacci LFSR; load shifts in an external bit, shift free-runs.
// pred_bit is combinational from the register; no backpressure, caller qualifies load/shift.
module prbs_lfsr
  import ibert_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  poly_t poly,
  input  logic  load,
  input  logic  shift,
  input  logic  load_bit,
  output logic  pred_bit
);

  logic [LFSR_W-1:0] lfsr;

  // lfsr[0] holds the newest bit, so lfsr[k-1] is the bit k steps back.
  assign pred_bit = lfsr[POLY_LEN[poly] - 5'd1] ^ lfsr[POLY_TAP[poly] - 5'd1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= {lfsr[LFSR_W-2:0], load_bit};
    end else if (shift) begin
      lfsr <= {lfsr[LFSR_W-2:0], pred_bit};
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: seeds, verifies, locks and counts bit errors; all outputs registered, 1-cycle latency.
// No backpressure: rx_valid qualifies every bit, idle cycles simply stall the state and counters.
module prbs_checker
  import ibert_pkg::*;
#(
  parameter int LOCK_CNT    = 32,
  parameter int LOSS_THRESH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  poly_sel,
  input  logic        rx_valid,
  input  logic        rx_bit,
  input  logic [24:0] window_len,
  input  logic        clear,
  output logic        locked,
  output logic        error_pulse,
  output logic [31:0] error_count,
  output logic [31:0] bit_count,
  output logic        done
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(BLOCK_SIZE);
  localparam int EW = BW + 1;
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLOCK_SIZE - 1);
  localparam logic [EW-1:0] LOSS_LIM  = EW'(LOSS_THRESH);

  state_t        state, state_nxt;
  poly_t         poly_q, poly_nxt;
  logic [4:0]    seed_cnt, seed_cnt_nxt;
  logic [MW-1:0] match_cnt, match_cnt_nxt;
  logic [BW-1:0] blk_bits, blk_bits_nxt;
  logic [EW-1:0] blk_errs, blk_errs_nxt, blk_errs_inc;
  logic [31:0]   err_nxt, bits_nxt;
  logic          pulse_nxt;
  logic          lfsr_load, lfsr_shift, pred_bit, mismatch;

  prbs_lfsr u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .poly     (poly_q),
    .load     (lfsr_load),
    .shift    (lfsr_shift),
    .load_bit (rx_bit),
    .pred_bit (pred_bit)
  );

  assign mismatch     = rx_bit ^ pred_bit;
  assign blk_errs_inc = blk_errs + EW'(mismatch);

  always_comb begin
    state_nxt     = state;
    poly_nxt      = poly_q;
    seed_cnt_nxt  = seed_cnt;
    match_cnt_nxt = match_cnt;
    blk_bits_nxt  = blk_bits;
    blk_errs_nxt  = blk_errs;
    err_nxt       = error_count;
    bits_nxt      = bit_count;
    pulse_nxt     = 1'b0;
    lfsr_load     = 1'b0;
    lfsr_shift    = 1'b0;

    if (clear) begin
      err_nxt       = '0;
      bits_nxt      = '0;
      seed_cnt_nxt  = '0;
      match_cnt_nxt = '0;
      blk_bits_nxt  = '0;
      blk_errs_nxt  = '0;
      state_nxt     = enable ? SEED : IDLE;
      if (state == IDLE) poly_nxt = poly_t'(poly_sel);
    end else if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          poly_nxt      = poly_t'(poly_sel);
          seed_cnt_nxt  = '0;
          match_cnt_nxt = '0;
          state_nxt     = SEED;
        end
        SEED: if (rx_valid) begin
          lfsr_load    = 1'b1;
          seed_cnt_nxt = seed_cnt + 5'd1;
          if (seed_cnt == POLY_LEN[poly_q] - 5'd1) begin
            seed_cnt_nxt  = '0;
            match_cnt_nxt = '0;
            state_nxt     = VERIFY;
          end
        end
        VERIFY: if (rx_valid) begin
          lfsr_shift = 1'b1;
          if (mismatch) begin
            seed_cnt_nxt  = '0;
            match_cnt_nxt = '0;
            state_nxt     = SEED;
          end else if (match_cnt == LOCK_LAST) begin
            match_cnt_nxt = '0;
            blk_bits_nxt  = '0;
            blk_errs_nxt  = '0;
            state_nxt     = LOCKED;
          end else begin
            match_cnt_nxt = match_cnt + MW'(1);
          end
        end
        LOCKED: if (rx_valid) begin
          lfsr_shift   = 1'b1;
          bits_nxt     = sat_inc(bit_count);
          blk_bits_nxt = blk_bits + BW'(1);
          blk_errs_nxt = blk_errs_inc;
          if (mismatch) begin
            err_nxt   = sat_inc(error_count);
            pulse_nxt = 1'b1;
          end
          // Block boundary: judge the block including this bit, then start a fresh tally.
          if (blk_bits == BLK_LAST) begin
            blk_errs_nxt = '0;
            if (blk_errs_inc >= LOSS_LIM) begin
              seed_cnt_nxt = '0;
              state_nxt    = SEED;
            end
          end
          if (window_len != '0 && bits_nxt >= {7'd0, window_len}) state_nxt = DONE;
        end
        DONE: lfsr_shift = rx_valid;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      poly_q      <= PRBS7;
      seed_cnt    <= '0;
      match_cnt   <= '0;
      blk_bits    <= '0;
      blk_errs    <= '0;
      error_count <= '0;
      bit_count   <= '0;
      error_pulse <= 1'b0;
      locked      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      poly_q      <= poly_nxt;
      seed_cnt    <= seed_cnt_nxt;
      match_cnt   <= match_cnt_nxt;
      blk_bits    <= blk_bits_nxt;
      blk_errs    <= blk_errs_nxt;
      error_count <= err_nxt;
      bit_count   <= bits_nxt;
      error_pulse <= pulse_nxt;
      locked      <= (state_nxt == LOCKED);
      done        <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed PRBS streams with injected flips, events checked by a queue-driven monitor.
module tb_prbs_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  poly_sel = 2'd0;
  logic        rx_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic [24:0] window_len = '0;
  logic        clear = 1'b0;
  logic        locked, error_pulse, done;
  logic [31:0] error_count, bit_count;

  prbs_checker dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .poly_sel    (poly_sel),
    .rx_valid    (rx_valid),
    .rx_bit      (rx_bit),
    .window_len  (window_len),
    .clear       (clear),
    .locked      (locked),
    .error_pulse (error_pulse),
    .error_count (error_count),
    .bit_count   (bit_count),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef enum int {EV_LOCK, EV_UNLOCK, EV_ERR, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       fed;
    longint   bitc;   // -1: not compared
    longint   errc;   // -1: not compared
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          bits_fed = 0;
  int          pulses = 0;
  logic [22:0] gen = 23'h5A5A5;
  int          gen_len = 7;
  int          gen_tap = 6;
  logic        prev_locked = 1'b0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (fed=%0d)", name, act, exp, bits_fed);
    end
  endtask

  function automatic void push(input ev_kind_t k, input int f, input longint b, input longint e);
    ev_t ev;
    ev.kind = k;
    ev.fed  = f;
    ev.bitc = b;
    ev.errc = e;
    exp_q.push_back(ev);
  endfunction

  task automatic compare_ev(input ev_kind_t k);
    ev_t ev;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got event at fed=%0d expected none", k.name(), bits_fed);
    end else begin
      ev = exp_q.pop_front();
      chk($sformatf("%s_kind", k.name()), k, ev.kind);
      chk($sformatf("%s_fed", k.name()), bits_fed, ev.fed);
      if (ev.bitc >= 0) chk($sformatf("%s_bit_count", k.name()), bit_count, ev.bitc);
      if (ev.errc >= 0) chk($sformatf("%s_error_count", k.name()), error_count, ev.errc);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per observed event.
  always @(negedge clock) begin
    if (reset) begin
      prev_locked = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (prev_locked && !locked) compare_ev(EV_UNLOCK);
      if (!prev_locked && locked) compare_ev(EV_LOCK);
      if (error_pulse) begin
        pulses++;
        compare_ev(EV_ERR);
      end
      if (!prev_done && done) compare_ev(EV_DONE);
      prev_locked = locked;
      prev_done   = done;
    end
  end

  task automatic set_gen(input int p);
    case (p)
      0: begin gen_len = 7;  gen_tap = 6;  end
      1: begin gen_len = 9;  gen_tap = 5;  end
      2: begin gen_len = 15; gen_tap = 14; end
      default: begin gen_len = 23; gen_tap = 18; end
    endcase
    gen = 23'h5A5A5;
  endtask

  task automatic send(input logic flip);
    logic b;
    b = gen[gen_len-1] ^ gen[gen_tap-1];
    gen = {gen[21:0], b};
    rx_bit = b ^ flip;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    bits_fed++;
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic start_test(input int p, input int w);
    enable = 1'b0;
    idle();
    poly_sel   = 2'(p);
    window_len = 25'(w);
    enable     = 1'b1;
    clear      = 1'b1;
    idle();
    clear    = 1'b0;
    bits_fed = 0;
    set_gen(p);
  endtask

  initial begin
    int k;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_done", done, 0);
    chk("rst_error_pulse", error_pulse, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_bit_count", bit_count, 0);
    reset = 1'b0;
    idle();

    // PRBS7 clean stream, 1000-bit window; poly_sel change after IDLE must be ignored
    start_test(0, 1000);
    poly_sel = 2'd3;
    push(EV_LOCK, 39, 0, 0);
    push(EV_UNLOCK, 1039, -1, -1);
    push(EV_DONE, 1039, 1000, 0);
    for (int i = 0; i < 1039; i++) send(1'b0);
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("done_hold", done, 1);
    chk("done_hold_bit_count", bit_count, 1000);
    chk("done_hold_error_count", error_count, 0);
    enable = 1'b0;
    idle();
    chk("disable_done", done, 0);
    chk("disable_bit_count_held", bit_count, 1000);

    // PRBS15, one flip every 100 locked bits, 10000-bit window
    start_test(2, 10000);
    pulses = 0;
    k = 0;
    push(EV_LOCK, 47, 0, 0);
    for (int i = 0; i < 10047; i++) begin
      logic f;
      f = (i >= 47) && ((i - 47) % 100 == 50);
      if (f) begin
        k++;
        push(EV_ERR, i + 1, i - 46, k);
      end
      send(f);
    end
    push(EV_UNLOCK, 10047, -1, -1);
    push(EV_DONE, 10047, 10000, 100);
    idle();
    chk("prbs15_pulses", pulses, 100);

    // PRBS9: 20 errors in the first locked block force loss, then relock with counters kept
    start_test(1, 0);
    k = 0;
    push(EV_LOCK, 41, 0, 0);
    for (int i = 0; i < 156; i++) begin
      logic f;
      f = (i >= 41) && (i < 61);
      if (f) begin
        k++;
        push(EV_ERR, i + 1, i - 40, k);
      end
      if (i == 104) push(EV_UNLOCK, 105, -1, -1);
      if (i == 145) push(EV_LOCK, 146, 64, 20);
      send(f);
    end
    push(EV_UNLOCK, 156, -1, -1);

    // PRBS7: mismatch on the 10th VERIFY bit, then clear with rx_valid while LOCKED
    start_test(0, 0);
    for (int i = 0; i < 86; i++) begin
      if (i == 55) push(EV_LOCK, 56, 0, 0);
      if (i == 60) push(EV_ERR, 61, 5, 1);
      if (i == 70) push(EV_ERR, 71, 15, 2);
      send((i == 16) || (i == 60) || (i == 70));
    end
    push(EV_UNLOCK, 86, -1, -1);
    clear    = 1'b1;
    rx_valid = 1'b1;
    rx_bit   = 1'b1;
    @(posedge clock);
    #1;
    clear    = 1'b0;
    rx_valid = 1'b0;
    chk("clear_error_count", error_count, 0);
    chk("clear_bit_count", bit_count, 0);
    chk("clear_locked", locked, 0);
    push(EV_LOCK, 125, 0, 0);
    for (int i = 0; i < 39; i++) send(1'b0);

    // Error counter saturation from a preloaded value
    for (int i = 0; i < 3; i++) send(1'b0);
    force dut.error_count = 32'hFFFF_FFFE;
    idle();
    release dut.error_count;
    for (int j = 0; j < 10; j++) begin
      if (j % 2 == 0) push(EV_ERR, bits_fed + 1, -1, 32'hFFFF_FFFF);
      send(j % 2 == 0);
    end
    chk("sat_error_count", error_count, 32'hFFFF_FFFF);
    chk("sat_bit_count", bit_count, 13);

    // Asynchronous reset mid-window, then re-acquire from IDLE
    for (int i = 0; i < 4; i++) send(1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error_pulse", error_pulse, 0);
    chk("midrst_error_count", error_count, 0);
    chk("midrst_bit_count", bit_count, 0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    bits_fed = 0;
    set_gen(0);
    idle();
    push(EV_LOCK, 39, 0, 0);
    for (int i = 0; i < 39; i++) send(1'b0);
    push(EV_UNLOCK, 39, -1, -1);
    enable = 1'b0;
    idle();
    idle();

    chk("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 32: consecutive matching bits required to declare lock.
REQ-002 SHALL have parameter LOSS_THRESH, default 16: errors within one 64-bit block that force loss of lock.
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  run checker; low returns to IDLE.
REQ-006 SHALL have port poly_sel  input  2  0=PRBS7 (x^7+x^6+1), 1=PRBS9 (x^9+x^5+1), 2=PRBS15 (x^15+x^14+1), 3=PRBS23 (x^23+x^18+1).
REQ-007 SHALL have port rx_valid  input  1  rx_bit qualifier.
REQ-008 SHALL have port rx_bit  input  1  received serial bit from the generator/error-injector path.
REQ-009 SHALL have port window_len  input  25  test length in locked bits; 0 = unlimited.
REQ-010 SHALL have port clear  input  1  synchronous clear of counters and re-acquire.
REQ-011 SHALL have port locked  output  1  high in LOCKED state.
REQ-012 SHALL have port error_pulse  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-013 SHALL have port error_count  output  32  total errors in window.
REQ-014 SHALL have port bit_count  output  32  total bits checked in window.
REQ-015 SHALL have port done  output  1  high in DONE state.

Function
REQ-016 SHALL implement states IDLE, SEED, VERIFY, LOCKED, DONE; the state and all counters advance only on cycles with rx_valid=1, except the enable and clear transitions.
REQ-017 IDLE: SHALL latch poly_sel and go to SEED when enable=1; poly_sel changes outside IDLE SHALL be ignored.
REQ-018 SEED: SHALL shift rx_bit into the 23-bit LFSR for N valid bits (N=7/9/15/23 per latched poly), then go to VERIFY.
REQ-019 VERIFY/LOCKED/DONE: LFSR SHALL free-run, predicted bit = XOR of the selected taps, shifted into the LFSR each valid cycle.
REQ-020 VERIFY: a match SHALL increment the match counter; a mismatch SHALL return to SEED with the match counter zeroed; LOCK_CNT matches SHALL enter LOCKED.
REQ-021 LOCKED: each valid bit SHALL increment bit_count; each mismatch SHALL increment error_count and assert error_pulse on the following cycle.
REQ-022 LOCKED: at each 64th bit, if block errors >= LOSS_THRESH the state SHALL go to SEED, counters held, and the block error counter SHALL reset every block.
REQ-023 When window_len != 0 and bit_count reaches window_len, the state SHALL go to DONE; counting stops; DONE holds until clear or enable=0.
REQ-024 Counters SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-025 enable=0 SHALL go to IDLE on the next edge, counters holding their values.
REQ-026 clear=1 SHALL zero all counters and enter SEED (if enable=1) or IDLE; clear takes priority over rx_valid in the same cycle.
REQ-027 Outputs SHALL be registered; error_pulse latency is one cycle after the sampled rx_bit.

Reset
REQ-028 reset SHALL asynchronously force state IDLE, LFSR to all-zeros, all counters 0, and locked=0, error_pulse=0, done=0, error_count=0, bit_count=0.
REQ-029 Reset asserted mid-test SHALL discard all results; the checker re-acquires from IDLE after release.

Structure
REQ-030 Package ibert_pkg SHALL hold the state enum, the poly_sel enum, the tap positions and lengths per polynomial, and the block size 64.
REQ-031 Sub-module prbs_lfsr (23-bit, poly-selectable, load/shift) SHALL be instantiated once and shared with the generator side.

Verification
REQ-032 PRBS7 clean stream, rx_valid=1, window_len=1000 -> locked after 7+32 bits, done with bit_count=1000, error_count=0.
REQ-033 PRBS15 with single-bit flips injected every 100 bits, window_len=10000 -> error_count=100, 100 error_pulse pulses.
REQ-034 Lock acquired, then 20 errors within one 64-bit block -> locked drops at block end, re-locks after N+32 clean bits, counters retain prior values.
REQ-035 Mismatch at the 10th VERIFY bit -> returns to SEED; lock only after 32 uninterrupted matches.
REQ-036 Preload error_count=32'hFFFFFFFE via a force, then 5 errors -> error_count=32'hFFFFFFFF.
REQ-037 clear and rx_valid in the same cycle during LOCKED -> counters 0, state SEED; reset pulse mid-window -> all outputs 0 immediately.
